// File: rtl/pmod_da2_tx_pkg.sv
// Shared types and constants for the Pmod DA2 transmit path.
package da2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_BITS  = 12;

  // DAC121S101 power-down field, shared by both converters.
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Frame layout: two don't-care zeros, power-down mode, then the code, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd,
                                                        input logic [DATA_BITS-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/pmod_da2_tx_if.sv
// Sample-pair stream: one valid/ready handshake carrying both channel codes.
interface pmod_da2_tx_if;

  logic                          s_valid;
  logic                          s_ready;
  logic [da2_pkg::DATA_BITS-1:0] s_data_a;
  logic [da2_pkg::DATA_BITS-1:0] s_data_b;
  logic [1:0]                    s_pd;

  modport master (
    output s_valid,
    output s_data_a,
    output s_data_b,
    output s_pd,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data_a,
    input  s_data_b,
    input  s_pd,
    output s_ready
  );

endinterface

// File: rtl/pmod_da2_tx_timer.sv
// Half-period timer: one-cycle tick every CLK_DIV enabled cycles.
module da2_half_period_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CntLast);

  // Next count: clear wins, otherwise count up and wrap on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmod_da2_tx.sv
// Pmod DA2 transmitter: serialises one accepted sample pair per 16-bit SPI frame.
module pmod_da2_tx
  import da2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  pmod_da2_tx_if.slave  s,
  output logic          dac_sclk,
  output logic          dac_sync_n,
  output logic          dac_dina,
  output logic          dac_dinb,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [4:0] BitLast = 5'(FRAME_BITS - 1);

  state_t                state_q, state_d;
  logic                  sclk_q, sclk_d;
  logic                  sync_n_q, sync_n_d;
  logic [FRAME_BITS-1:0] sh_a_q, sh_a_d;
  logic [FRAME_BITS-1:0] sh_b_q, sh_b_d;
  logic [4:0]            bit_q, bit_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  tick;

  assign s.s_ready = (state_q == IDLE) && !reset;
  assign accept    = s.s_valid && s.s_ready;

  da2_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(state_q == SHIFT),
    .tick  (tick)
  );

  // Next-state logic: load on accept, fall/rise SCLK on ticks, shift on rises.
  always_comb begin
    state_d  = state_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          sh_a_d   = build_frame(s.s_pd, s.s_data_a);
          sh_b_d   = build_frame(s.s_pd, s.s_data_b);
          bit_d    = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: DAC samples the bit currently presented.
            sclk_d = 1'b0;
          end else if (bit_q == BitLast) begin
            // End of the 16th low half-period closes the frame.
            state_d  = GAP;
            sync_n_d = 1'b1;
            sclk_d   = 1'b1;
            sh_a_d   = '0;
            sh_b_d   = '0;
            bit_d    = '0;
            gap_d    = '0;
            done_d   = 1'b1;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 5'd1;
            sh_a_d = {sh_a_q[FRAME_BITS-2:0], 1'b0};
            sh_b_d = {sh_b_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_q == GapLast) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_dina   = sh_a_q[FRAME_BITS-1];
  assign dac_dinb   = sh_b_q[FRAME_BITS-1];
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pmod_da2_tx.sv
// Bench for pmod_da2_tx: two instances (default timing and fastest timing) watched
// by a pin-level model that decodes frames from SCLK/SYNC and predicts handshake timing.
module tb_pmod_da2_tx;

  localparam int D0 = 2;
  localparam int G0 = 4;
  localparam int D1 = 1;
  localparam int G1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmod_da2_tx_if if0 ();
  pmod_da2_tx_if if1 ();

  logic [1:0] sclk_w, sync_w, dina_w, dinb_w, busy_w, done_w, ready_w, valid_w;
  logic [11:0] a_w [2];
  logic [11:0] b_w [2];
  logic [1:0]  pd_w [2];

  pmod_da2_tx #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .reset(reset), .s(if0),
    .dac_sclk(sclk_w[0]), .dac_sync_n(sync_w[0]), .dac_dina(dina_w[0]),
    .dac_dinb(dinb_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  pmod_da2_tx #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(reset), .s(if1),
    .dac_sclk(sclk_w[1]), .dac_sync_n(sync_w[1]), .dac_dina(dina_w[1]),
    .dac_dinb(dinb_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  assign ready_w[0] = if0.s_ready;
  assign ready_w[1] = if1.s_ready;
  assign valid_w[0] = if0.s_valid;
  assign valid_w[1] = if1.s_valid;
  assign a_w[0] = if0.s_data_a;
  assign a_w[1] = if1.s_data_a;
  assign b_w[0] = if0.s_data_b;
  assign b_w[1] = if1.s_data_b;
  assign pd_w[0] = if0.s_pd;
  assign pd_w[1] = if1.s_pd;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model state, owned by the monitor process.
  int          cyc = 0;
  logic        prev_reset;
  logic        started = 1'b0;
  logic        prev_sclk [2];
  logic        prev_sync [2];
  logic        prev_ready [2];
  logic        pending [2];
  logic        active [2];
  logic        await_ready [2];
  logic        have_last [2];
  int          acc_cyc [2];
  int          last_acc [2];
  logic [15:0] pend_a [2];
  logic [15:0] pend_b [2];
  logic [15:0] wa [2];
  logic [15:0] wb [2];
  int          low_cnt [2];
  int          falls [2];
  int          idle_edges [2] = '{0, 0};
  int          busy_err [2] = '{0, 0};
  int          spurious_done [2] = '{0, 0};
  int          n_acc [2] = '{0, 0};
  int          n_frames [2] = '{0, 0};
  // Written only by the stimulus process: expect back-to-back accept spacing.
  logic        b2b [2] = '{1'b0, 1'b0};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int  dv, gv, flen, period;
      logic exp_busy;
      dv = (d == 0) ? D0 : D1;
      gv = (d == 0) ? G0 : G1;
      flen = 32 * dv;
      period = 1 + flen + gv;
      if (prev_reset === 1'b1) begin
        check($sformatf("rst_sclk%0d", d), sclk_w[d], 1);
        check($sformatf("rst_sync%0d", d), sync_w[d], 1);
        check($sformatf("rst_din%0d", d), {dina_w[d], dinb_w[d]}, 0);
        check($sformatf("rst_busy%0d", d), busy_w[d], 0);
        check($sformatf("rst_done%0d", d), done_w[d], 0);
        pending[d] = 1'b0;
        active[d] = 1'b0;
        await_ready[d] = 1'b0;
        have_last[d] = 1'b0;
        low_cnt[d] = 0;
        falls[d] = 0;
        started = 1'b1;
      end else if (started) begin
        if (!sync_w[d] && prev_sync[d]) begin
          check($sformatf("sync_fall_time%0d", d), cyc, acc_cyc[d] + 1);
          check($sformatf("sync_fall_sclk%0d", d), sclk_w[d], 1);
          low_cnt[d] = 0;
          falls[d] = 0;
          wa[d] = '0;
          wb[d] = '0;
        end
        if (!sync_w[d]) begin
          low_cnt[d]++;
          if (prev_sclk[d] && !sclk_w[d]) begin
            falls[d]++;
            wa[d] = {wa[d][14:0], dina_w[d]};
            wb[d] = {wb[d][14:0], dinb_w[d]};
          end
        end
        if (sync_w[d] && prev_sync[d] && (sclk_w[d] != prev_sclk[d])) idle_edges[d]++;
        if (sync_w[d] && !prev_sync[d]) begin
          check($sformatf("frame_len%0d", d), low_cnt[d], flen);
          check($sformatf("falls%0d", d), falls[d], 16);
          check($sformatf("dina_word%0d", d), wa[d], pend_a[d]);
          check($sformatf("dinb_word%0d", d), wb[d], pend_b[d]);
          check($sformatf("frame_done%0d", d), done_w[d], 1);
          check($sformatf("sync_rise_time%0d", d), cyc, acc_cyc[d] + 1 + flen);
          check($sformatf("end_pins%0d", d), {sclk_w[d], dina_w[d], dinb_w[d]}, 3'b100);
          pending[d] = 1'b0;
          await_ready[d] = 1'b1;
          n_frames[d]++;
        end else if (done_w[d]) begin
          spurious_done[d]++;
        end
        if (ready_w[d] && !prev_ready[d] && await_ready[d]) begin
          check($sformatf("ready_time%0d", d), cyc, acc_cyc[d] + period);
          check($sformatf("busy_ready_trace%0d", d), busy_err[d], 0);
          check($sformatf("idle_edges%0d", d), idle_edges[d], 0);
          await_ready[d] = 1'b0;
        end
      end
      if (started) begin
        exp_busy = active[d] && (cyc >= acc_cyc[d] + 1) && (cyc < acc_cyc[d] + period);
        if (busy_w[d] !== exp_busy) busy_err[d]++;
        if (ready_w[d] !== (!reset && !exp_busy)) busy_err[d]++;
        if (valid_w[d] && ready_w[d]) begin
          check($sformatf("double_accept%0d", d), pending[d], 0);
          if (b2b[d] && have_last[d]) check($sformatf("b2b_period%0d", d), cyc - last_acc[d], period);
          have_last[d] = b2b[d];
          last_acc[d] = cyc;
          pending[d] = 1'b1;
          active[d] = 1'b1;
          acc_cyc[d] = cyc;
          pend_a[d] = {2'b00, pd_w[d], a_w[d]};
          pend_b[d] = {2'b00, pd_w[d], b_w[d]};
          n_acc[d]++;
        end
      end
      if (reset) check($sformatf("ready_in_reset%0d", d), ready_w[d], 0);
      prev_sclk[d] = sclk_w[d];
      prev_sync[d] = sync_w[d];
      prev_ready[d] = ready_w[d];
    end
    prev_reset = reset;
    cyc++;
  end

  task automatic drive(input int d, input logic v, input logic [11:0] a, input logic [11:0] b,
                       input logic [1:0] pd);
    if (d == 0) begin
      if0.s_valid = v; if0.s_data_a = a; if0.s_data_b = b; if0.s_pd = pd;
    end else begin
      if1.s_valid = v; if1.s_data_a = a; if1.s_data_b = b; if1.s_pd = pd;
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) if0.s_valid = v;
    else if1.s_valid = v;
  endtask

  // Returns in the cycle after the accept edge, inputs still holding their values.
  task automatic wait_accept(input int d);
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_w[d] && ready_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [11:0] a, input logic [11:0] b,
                      input logic [1:0] pd);
    @(posedge clk);
    #1;
    drive(d, 1'b1, a, b, pd);
    wait_accept(d);
    set_valid(d, 1'b0);
  endtask

  task automatic wait_idle(input int d);
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready_w[d] && !busy_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int acc_before;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 2'b00);
    drive(1, 1'b0, '0, '0, 2'b00);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;

    // Single frame, then power-down code with boundary codes.
    send(0, 12'hA5C, 12'h3F0, 2'b00);
    wait_idle(0);
    send(0, 12'hFFF, 12'h000, 2'b11);
    wait_idle(0);

    // Continuous valid with incrementing data: three frames.
    b2b[0] = 1'b1;
    acc_before = n_acc[0];
    @(posedge clk);
    #1 drive(0, 1'b1, 12'h100, 12'h200, 2'b00);
    for (int k = 0; k < 3; k++) begin
      wait_accept(0);
      drive(0, k < 2, 12'h101 + 12'(k), 12'h201 + 12'(k), 2'b00);
    end
    check("b2b_count", n_acc[0] - acc_before, 3);
    wait_idle(0);
    b2b[0] = 1'b0;

    // Input changes while busy must not reach the frame in flight.
    send(0, 12'h5A5, 12'hC3C, 2'b01);
    repeat (10) @(posedge clk);
    #1 drive(0, 1'b0, 12'($urandom), 12'($urandom), 2'b10);
    @(negedge clk);
    check("ready_while_busy", ready_w[0], 0);
    wait_idle(0);

    // Reset in cycle T+20 aborts the frame; a fresh frame follows.
    send(0, 12'h123, 12'h456, 2'b00);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send(0, 12'h9E7, 12'h0C1, 2'b10);
    wait_idle(0);

    // Fastest timing instance.
    send(1, 12'hA5C, 12'h3F0, 2'b00);
    wait_idle(1);

    // Randomised frames on both instances.
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 2; d++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        send(d, 12'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
      end
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(posedge clk);

    check("frames0", n_frames[0], n_acc[0] - 1);
    check("accepts0", n_acc[0], 14);
    check("frames1", n_frames[1], n_acc[1]);
    check("accepts1", n_acc[1], 7);
    check("spurious_done0", spurious_done[0], 0);
    check("spurious_done1", spurious_done[1], 0);
    check("idle_edges_all", idle_edges[0] + idle_edges[1], 0);
    check("busy_ready_all", busy_err[0] + busy_err[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
